// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: operation
// encodings, controller state encoding and a small decode helper.
package muldiv_ctrl_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_WAIT = 2'b01,
    ST_DIV_RUN  = 2'b10,
    ST_DONE     = 2'b11
  } md_state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multiplier/divider: latches one EX request, stalls
// EX until the 64-bit {hi,lo} result is available, then issues one HI/LO write.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     src1_i,
  input  logic [WIDTH-1:0]     src2_i,
  input  logic                 flush_i,
  input  logic                 hold_i,
  output logic                 stallreq_o,
  output logic                 mul_signed_o,
  output logic [WIDTH-1:0]     mul_a_o,
  output logic [WIDTH-1:0]     mul_b_o,
  input  logic [2*WIDTH-1:0]   mul_result_i,
  output logic                 div_start_o,
  output logic                 div_signed_o,
  output logic [WIDTH-1:0]     div_op1_o,
  output logic [WIDTH-1:0]     div_op2_o,
  output logic                 div_annul_o,
  input  logic                 div_ready_i,
  input  logic [2*WIDTH-1:0]   div_result_i,
  output logic                 hilo_we_o,
  output logic [WIDTH-1:0]     hi_wdata_o,
  output logic [WIDTH-1:0]     lo_wdata_o
);

  localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  md_state_t         state, state_next;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  opnd_a, opnd_b;
  logic [WIDTH-1:0]  hi_res, lo_res;
  logic              mul_signed, div_signed;
  logic              accept, mul_done, div_done;
  logic              stall, start, annul, we;

  // Control outputs are gated by rst so nothing leaks out while resetting.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_done   = 1'b0;
    div_done   = 1'b0;
    stall      = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    we         = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (op_valid_i && !flush_i) begin
            stall  = 1'b1;
            accept = 1'b1;
            if (!is_div_op(op_i))
              state_next = ST_MUL_WAIT;
            else if (src2_i == '0)
              state_next = ST_DONE;
            else
              state_next = ST_DIV_RUN;
          end
        end
        ST_MUL_WAIT: begin
          if (flush_i) begin
            state_next = ST_IDLE;
          end else begin
            stall = 1'b1;
            if (cnt == '0) begin
              mul_done   = 1'b1;
              state_next = ST_DONE;
            end
          end
        end
        ST_DIV_RUN: begin
          if (flush_i) begin
            annul      = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stall = 1'b1;
            start = !div_ready_i;
            if (div_ready_i) begin
              div_done   = 1'b1;
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (flush_i) begin
            state_next = ST_IDLE;
          end else if (!hold_i) begin
            we         = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A zero divisor skips the divider entirely, so the result is cleared here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      opnd_a     <= '0;
      opnd_b     <= '0;
      hi_res     <= '0;
      lo_res     <= '0;
      mul_signed <= 1'b0;
      div_signed <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        opnd_a     <= src1_i;
        opnd_b     <= src2_i;
        mul_signed <= (op_i == MD_MULT);
        div_signed <= (op_i == MD_DIV);
        cnt        <= CW'(MUL_LAT);
        if (is_div_op(op_i) && src2_i == '0) begin
          hi_res <= '0;
          lo_res <= '0;
        end
      end else if (state == ST_MUL_WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (mul_done)
        {hi_res, lo_res} <= mul_result_i;
      if (div_done)
        {hi_res, lo_res} <= div_result_i;
    end
  end

  assign stallreq_o   = stall;
  assign div_start_o  = start;
  assign div_annul_o  = annul;
  assign hilo_we_o    = we;
  assign mul_signed_o = mul_signed;
  assign mul_a_o      = opnd_a;
  assign mul_b_o      = opnd_b;
  assign div_signed_o = div_signed;
  assign div_op1_o    = opnd_a;
  assign div_op2_o    = opnd_b;
  assign hi_wdata_o   = hi_res;
  assign lo_wdata_o   = lo_res;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a 2-stage multiplier model and a
// fixed-latency divider model; expected HI/LO values are hand-computed.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int MUL_LAT = 2;
  localparam int WIDTH   = 32;
  localparam int DIV_CYC = 32;

  logic              clk;
  logic              rst;
  logic              op_valid_i;
  logic [1:0]        op_i;
  logic [31:0]       src1_i, src2_i;
  logic              flush_i, hold_i;
  logic              stallreq_o;
  logic              mul_signed_o;
  logic [31:0]       mul_a_o, mul_b_o;
  logic [63:0]       mul_result_i;
  logic              div_start_o, div_signed_o;
  logic [31:0]       div_op1_o, div_op2_o;
  logic              div_annul_o;
  logic              div_ready_i;
  logic [63:0]       div_result_i;
  logic              hilo_we_o;
  logic [31:0]       hi_wdata_o, lo_wdata_o;

  int vectors     = 0;
  int miscompares = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid_i   (op_valid_i),
    .op_i         (op_i),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .stallreq_o   (stallreq_o),
    .mul_signed_o (mul_signed_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_result_i (mul_result_i),
    .div_start_o  (div_start_o),
    .div_signed_o (div_signed_o),
    .div_op1_o    (div_op1_o),
    .div_op2_o    (div_op2_o),
    .div_annul_o  (div_annul_o),
    .div_ready_i  (div_ready_i),
    .div_result_i (div_result_i),
    .hilo_we_o    (hilo_we_o),
    .hi_wdata_o   (hi_wdata_o),
    .lo_wdata_o   (lo_wdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: MUL_LAT register stages after the operand registers.
  function automatic logic [63:0] mulModel(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] divModel(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  logic [63:0] mul_p1, mul_p2;
  always_ff @(posedge clk) begin
    mul_p1 <= mulModel(mul_a_o, mul_b_o, mul_signed_o);
    mul_p2 <= mul_p1;
  end
  assign mul_result_i = mul_p2;

  logic        div_busy;
  logic [7:0]  div_cnt;
  logic [63:0] div_res;
  always_ff @(posedge clk) begin
    div_ready_i <= 1'b0;
    if (rst) begin
      div_busy <= 1'b0;
      div_cnt  <= '0;
      div_res  <= '0;
    end else if (div_annul_o) begin
      div_busy <= 1'b0;
    end else if (!div_busy) begin
      if (div_start_o) begin
        div_busy <= 1'b1;
        div_cnt  <= 8'(DIV_CYC - 1);
        div_res  <= divModel(div_op1_o, div_op2_o, div_signed_o);
      end
    end else if (div_cnt == 8'd0) begin
      div_busy    <= 1'b0;
      div_ready_i <= 1'b1;
    end else begin
      div_cnt <= div_cnt - 8'd1;
    end
  end
  assign div_result_i = div_res;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic flush, input logic hold);
    op_valid_i = valid;
    op_i       = op;
    src1_i     = a;
    src2_i     = b;
    flush_i    = flush;
    hold_i     = hold;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one op (entered 1 time unit after an edge) and follows it to its write.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_stall,
                       input int exp_start, input int hold_cycles, input bit idle_after);
    int stalls, starts, wes;
    bit done;
    stalls = 0; starts = 0; wes = 0; done = 1'b0;
    applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (stallreq_o) begin
        stalls++;
        if (div_start_o) starts++;
        if (hilo_we_o) wes++;
        nextCycle();
        applyStimulus(1'b1, op, ~a, ~b, 1'b0, 1'b0);
      end else begin
        done = 1'b1;
      end
    end
    checkOutput({tag, " finished"}, 64'(done), 64'd1);
    checkOutput({tag, " stall cycles"}, 64'(stalls), 64'(exp_stall));
    checkOutput({tag, " div_start cycles"}, 64'(starts), 64'(exp_start));
    checkOutput({tag, " early write"}, 64'(wes), 64'd0);
    for (int h = 0; h < hold_cycles; h++) begin
      hold_i = 1'b1;
      #1;
      checkOutput({tag, " we under hold"}, 64'(hilo_we_o), 64'd0);
      checkOutput({tag, " hi under hold"}, 64'(hi_wdata_o), 64'(exp_hi));
      checkOutput({tag, " lo under hold"}, 64'(lo_wdata_o), 64'(exp_lo));
      nextCycle();
      #1;
    end
    hold_i = 1'b0;
    #1;
    checkOutput({tag, " hilo_we"}, 64'(hilo_we_o), 64'd1);
    checkOutput({tag, " hi"}, 64'(hi_wdata_o), 64'(exp_hi));
    checkOutput({tag, " lo"}, 64'(lo_wdata_o), 64'(exp_lo));
    checkOutput({tag, " operand a kept"}, 64'(op[1] ? div_op1_o : mul_a_o), 64'(a));
    checkOutput({tag, " operand b kept"}, 64'(op[1] ? div_op2_o : mul_b_o), 64'(b));
    if (!op[1])
      checkOutput({tag, " mul_signed"}, 64'(mul_signed_o), 64'(op == MD_MULT));
    else
      checkOutput({tag, " div_signed"}, 64'(div_signed_o), 64'(op == MD_DIV));
    nextCycle();
    if (idle_after) begin
      applyStimulus(1'b0, MD_MULT, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      checkOutput({tag, " no repeat write"}, 64'(hilo_we_o), 64'd0);
      checkOutput({tag, " idle stallreq"}, 64'(stallreq_o), 64'd0);
      nextCycle();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wes, starts;
    rst = 1'b1;
    applyStimulus(1'b1, MD_DIV, 32'h1234, 32'h5, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset stallreq", 64'(stallreq_o), 64'd0);
    checkOutput("reset div_start", 64'(div_start_o), 64'd0);
    checkOutput("reset hilo_we", 64'(hilo_we_o), 64'd0);
    checkOutput("reset mul_a", 64'(mul_a_o), 64'd0);
    checkOutput("reset hi", 64'(hi_wdata_o), 64'd0);
    checkOutput("reset mul_signed", 64'(mul_signed_o), 64'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, MD_MULT, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("post-reset stallreq", 64'(stallreq_o), 64'd0);
    checkOutput("post-reset div_signed", 64'(div_signed_o), 64'd0);
    checkOutput("post-reset lo", 64'(lo_wdata_o), 64'd0);
    checkOutput("post-reset div_op2", 64'(div_op2_o), 64'd0);
    nextCycle();

    runOp("multu", MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE, 4, 0, 0, 1'b1);
    runOp("div -7/2", MD_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35, 33, 0, 1'b1);
    runOp("divu 5/0", MD_DIVU, 32'h5, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1'b1);

    // Abort a divide on its tenth DIV_RUN cycle.
    applyStimulus(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    #1;
    checkOutput("flush accept stallreq", 64'(stallreq_o), 64'd1);
    nextCycle();
    repeat (9) nextCycle();
    #1;
    checkOutput("flush pre div_start", 64'(div_start_o), 64'd1);
    flush_i = 1'b1;
    #1;
    checkOutput("flush div_annul", 64'(div_annul_o), 64'd1);
    checkOutput("flush div_start", 64'(div_start_o), 64'd0);
    checkOutput("flush hilo_we", 64'(hilo_we_o), 64'd0);
    nextCycle();
    applyStimulus(1'b0, MD_MULT, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("after flush annul", 64'(div_annul_o), 64'd0);
    checkOutput("after flush stallreq", 64'(stallreq_o), 64'd0);
    wes = 0;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      #1;
      if (hilo_we_o) wes++;
      if (div_start_o) starts++;
    end
    nextCycle();
    checkOutput("after flush writes", 64'(wes), 64'd0);
    checkOutput("after flush starts", 64'(starts), 64'd0);
    runOp("mult 3*4", MD_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 4, 0, 0, 1'b1);

    runOp("multu hold", MD_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 4, 0, 3, 1'b1);

    runOp("mult -2*3", MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 4, 0, 0, 1'b0);
    runOp("divu 9/4", MD_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 35, 33, 0, 1'b1);

    applyStimulus(1'b1, MD_MULT, 32'h55, 32'h66, 1'b1, 1'b0);
    #1;
    checkOutput("idle flush stallreq", 64'(stallreq_o), 64'd0);
    nextCycle();
    applyStimulus(1'b0, MD_MULT, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("idle flush no latch", 64'(mul_a_o), 64'd9);
    checkOutput("idle flush still idle", 64'(stallreq_o), 64'd0);
    nextCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
